// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, bridge FSM states and byte-lane helpers for ahb_to_bus_protocol
package ahb_pkg;
  typedef enum logic [1:0] {TR_IDLE, TR_BUSY, TR_NONSEQ, TR_SEQ} htrans_t;
  typedef enum logic [2:0] {SZ_BYTE, SZ_HALF, SZ_WORD} hsize_t;
  typedef enum logic {RESP_OKAY, RESP_ERROR} hresp_t;
  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} ahb2bp_state_t;
  function automatic logic [3:0] ahb_strobe(input logic [2:0] hsize, input logic [1:0] addr_lo);
    return hsize == SZ_BYTE ? 4'b0001 << addr_lo :
           hsize == SZ_HALF ? 4'b0011 << {addr_lo[1], 1'b0} : 4'hF;
  endfunction
  function automatic logic ahb_misaligned(input logic [2:0] hsize, input logic [1:0] addr_lo);
    return (hsize == SZ_HALF && addr_lo[0]) || (hsize == SZ_WORD && addr_lo != 2'd0) || hsize > SZ_WORD;
  endfunction
endpackage

// File: rtl/ahb_to_bus_protocol.sv
// ahb_to_bus_protocol: AHB-Lite subordinate to flat bus-protocol bridge; AHB2BP_RDATA_REG_EN registers read data/error
module ahb_to_bus_protocol
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int STALL_TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  wen,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [31:0]           wdata,
  output logic [3:0]            strobe,
  input  logic [31:0]           rdata,
  input  logic                  error,
  input  logic                  request_stall
);
  localparam int CW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);
`ifdef AHB2BP_RDATA_REG_EN
  localparam bit RD_REG = 1'b1;
`else
  localparam bit RD_REG = 1'b0;
`endif
  ahb2bp_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [3:0]            strobe_q, strobe_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cap_q, cap_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  accept, bad, timeout, take;
  assign accept  = HSEL & HREADY & (HTRANS == TR_NONSEQ || HTRANS == TR_SEQ);
  assign bad     = ahb_misaligned(HSIZE, HADDR[1:0]);
  assign timeout = (STALL_TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign addr    = addr_q;
  // A bus error holds HREADYOUT low so the OKAY-looking cycle never completes the transfer
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    strobe_d  = strobe_q;
    cnt_d     = cnt_q;
    cap_d     = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    take      = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = RESP_OKAY;
    HRDATA    = '0;
    wen       = 1'b0;
    ren       = 1'b0;
    wdata     = '0;
    strobe    = '0;
    case (state_q)
      DATA: if (cap_q) begin
        HRDATA    = rdata_q;
        HREADYOUT = !err_q;
        take      = !err_q;
        if (err_q) state_d = ERR1;
      end else begin
        wen       = write_q;
        ren       = !write_q;
        strobe    = strobe_q;
        wdata     = write_q ? HWDATA : '0;
        HRDATA    = rdata;
        HREADYOUT = !request_stall & !error;
        if (request_stall) begin
          cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
          if (timeout) state_d = ERR1;
        end else if (RD_REG && !write_q) begin
          cap_d     = 1'b1;
          rdata_d   = rdata;
          err_d     = error;
          HREADYOUT = 1'b0;
        end else if (error) state_d = ERR1;
        else take = 1'b1;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = RESP_ERROR;
        state_d   = ERR2;
      end
      ERR2: begin
        HRESP = RESP_ERROR;
        take  = 1'b1;
      end
      default: take = 1'b1;
    endcase
    if (take) begin
      state_d = accept ? (bad ? ERR1 : DATA) : IDLE;
      if (accept) begin
        addr_d   = HADDR;
        write_d  = HWRITE;
        strobe_d = ahb_strobe(HSIZE, HADDR[1:0]);
        cnt_d    = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      strobe_q <= '0;
      cnt_q    <= '0;
      cap_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      strobe_q <= strobe_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_ahb_to_bus_protocol.sv
// tb_ahb_to_bus_protocol: randomized scoreboard bench for ahb_to_bus_protocol with a queue-based master/consumer model
module tb_ahb_to_bus_protocol;
  localparam int TO = 4;
  typedef struct {logic err; logic wr; logic [31:0] rd; int waits;} ahb_exp_t;
  typedef struct {logic wr; logic [31:0] a; logic [3:0] st; logic [31:0] d;} bus_exp_t;
  typedef struct {int stall; logic [31:0] rd; logic err;} cons_t;
  logic        clk = 1'b0, nReset = 1'b0;
  logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY;
  logic [31:0] HADDR = '0, HWDATA = '0, HRDATA, wdata, addr, rdata = '0;
  logic [1:0]  HTRANS = 2'd0;
  logic [2:0]  HSIZE = 3'd0;
  logic        HREADYOUT, HRESP, wen, ren, error = 1'b0, request_stall = 1'b0;
  logic [3:0]  strobe;
  int checks = 0, fails = 0, cyc = 0;
  ahb_exp_t exp_q[$];
  bus_exp_t bus_q[$];
  cons_t    cons_q[$];
  int       stamps[$];
  assign HREADY = HREADYOUT;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  ahb_to_bus_protocol #(.ADDR_WIDTH(32), .STALL_TIMEOUT(TO)) dut (
    .clk(clk), .nReset(nReset), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .wen(wen), .ren(ren), .addr(addr), .wdata(wdata), .strobe(strobe),
    .rdata(rdata), .error(error), .request_stall(request_stall)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [3:0] lanes(input int sz, input logic [31:0] a);
    int n = 1 << sz;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction
  task automatic xfer(input logic sel, input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz,
                      input logic wr, input logic [31:0] d, input int stall, input logic cerr, input logic [31:0] rd);
    bit bad, tmo, ok;
    int n;
    ahb_exp_t e;
    cons_t c;
    bus_exp_t b;
    HSEL = sel; HTRANS = tr; HADDR = a; HSIZE = sz; HWRITE = wr;
    if (sel && tr[1]) begin
      bad = sz > 2 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'd0);
      tmo = !bad && stall >= TO;
      e.err = bad || tmo || cerr; e.wr = wr; e.rd = rd;
      e.waits = bad ? 1 : tmo ? TO + 1 : cerr ? -1 : stall;
      exp_q.push_back(e);
      if (!bad) begin c.stall = stall; c.rd = rd; c.err = cerr; cons_q.push_back(c); end
      if (!bad && !tmo) begin b.wr = wr; b.a = a; b.st = lanes(int'(sz), a); b.d = d; bus_q.push_back(b); end
    end
    n = 0;
    do begin @(negedge clk); ok = HREADYOUT; @(posedge clk); n++; end while (!ok && n < 100);
    if (!ok) begin checks++; fails++; $display("FAIL accept_timeout: got HREADYOUT=0 expected 1 within 100 cycles"); end
    #1;
    HWDATA = (sel && tr[1] && wr) ? d : '0;
  endtask
  task automatic drain();
    int n = 0;
    HSEL = 1'b0; HTRANS = 2'd0;
    while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    check("drain", 32'(exp_q.size() + bus_q.size()), 0);
  endtask
  int rem = 0;
  bit active = 1'b0;
  cons_t cc;
  always begin
    @(posedge clk); #2;
    if (!nReset) begin
      active = 1'b0; request_stall = 1'b0; error = 1'b0;
    end else if (wen || ren) begin
      if (!active) begin
        active = 1'b1;
        if (cons_q.size() == 0) begin
          checks++; fails++; rem = 0; cc.rd = '0; cc.err = 1'b0;
          $display("FAIL consumer_request: got unexpected request at %h expected none", addr);
        end else begin cc = cons_q.pop_front(); rem = cc.stall; end
      end
      request_stall = rem > 0;
      error = rem > 0 ? 1'($urandom % 2) : cc.err;
      rdata = rem > 0 ? $urandom : cc.rd;
      if (rem > 0) rem--; else active = 1'b0;
    end else begin
      active = 1'b0; request_stall = 1'b0; error = 1'b0;
    end
  end
  bit dp = 1'b0;
  int waits = 0;
  ahb_exp_t me;
  always @(negedge clk) begin
    if (!nReset) begin
      dp = 1'b0; waits = 0;
    end else begin
      if (dp && !HREADYOUT) waits++;
      else if (dp) begin
        if (exp_q.size() == 0) check("ahb_spurious_completion", 32'd1, 32'd0);
        else begin
          me = exp_q.pop_front();
          check("hresp", 32'(HRESP), 32'(me.err));
          if (!me.wr && !me.err) check("hrdata", HRDATA, me.rd);
          if (me.waits >= 0) check("wait_cycles", waits, me.waits);
        end
        waits = 0;
      end
      if (HREADYOUT) dp = HSEL & HTRANS[1];
    end
  end
  bus_exp_t mb;
  always @(negedge clk) begin
    if (nReset) begin
      if (!wen) check("wdata_idle", wdata, 0);
      if ((wen || ren) && !request_stall) begin
        stamps.push_back(cyc);
        if (bus_q.size() == 0) check("bus_spurious_request", 32'd1, 32'd0);
        else begin
          mb = bus_q.pop_front();
          check("wen", 32'(wen), 32'(mb.wr));
          check("ren", 32'(ren), 32'(!mb.wr));
          check("addr", addr, mb.a);
          check("strobe", 32'(strobe), 32'(mb.st));
          if (mb.wr) check("wdata", wdata, mb.d);
        end
      end
    end
  end
  initial begin
    logic [31:0] a;
    logic [2:0] sz;
    int st, r;
    cons_t c;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hreadyout", 32'(HREADYOUT), 1);
    check("rst_hresp", 32'(HRESP), 0);
    check("rst_hrdata", HRDATA, 0);
    check("rst_wen_ren", 32'({wen, ren}), 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_strobe", 32'(strobe), 0);
    nReset = 1'b1;
    @(posedge clk); #1;
    xfer(1, 2'd2, 32'h04, 3'd2, 1, 32'hDEADBEEF, 0, 0, 0); drain();
    xfer(1, 2'd2, 32'h07, 3'd0, 0, 0, 3, 0, 32'h5A000000); drain();
    xfer(1, 2'd2, 32'h01, 3'd1, 1, 32'h1111, 0, 0, 0); drain();
    stamps.delete();
    xfer(1, 2'd2, 32'h00, 3'd2, 1, 32'hCAFEF00D, 0, 0, 0);
    xfer(1, 2'd2, 32'h08, 3'd2, 0, 0, 0, 0, 32'h12345678);
    drain();
    check("back_to_back_gap", stamps.size() == 2 ? 32'(stamps[1] - stamps[0]) : 32'hFFFFFFFF, 1);
    xfer(1, 2'd2, 32'h0C, 3'd2, 0, 0, 50, 0, 32'h0BAD0BAD); drain();
    xfer(1, 2'd2, 32'h10, 3'd2, 1, 32'h77, 2, 1, 0); drain();
    for (int i = 0; i < 300; i++) begin
      r = $urandom % 10;
      st = r < 6 ? 0 : r < 9 ? 1 + $urandom % 3 : 6;
      sz = ($urandom % 8 == 0) ? 3'd3 : 3'($urandom % 3);
      a = $urandom & 32'hFFF;
      if ($urandom % 4 != 0 && sz < 3) a = a & ~((32'd1 << sz) - 1);
      if ($urandom % 6 == 0) xfer(1'($urandom % 2), 2'($urandom % 2), a, sz, 1'($urandom % 2), $urandom, 0, 0, 0);
      else if ($urandom % 12 == 0) xfer(0, 2'd2, a, sz, 1'($urandom % 2), $urandom, 0, 0, 0);
      else xfer(1, 2'd2 + 2'($urandom % 2), a, sz, 1'($urandom % 2), $urandom, st, $urandom % 8 == 0, $urandom);
    end
    drain();
    c.stall = 3; c.rd = '0; c.err = 1'b0;
    cons_q.push_back(c);
    HSEL = 1; HTRANS = 2'd2; HADDR = 32'h20; HSIZE = 3'd2; HWRITE = 1;
    @(posedge clk); #1;
    HSEL = 0; HTRANS = 2'd0; HWDATA = 32'h1234;
    @(posedge clk); #3;
    check("stalled_write_wen", 32'(wen), 1);
    nReset = 1'b0; #1;
    check("reset_wen", 32'(wen), 0);
    check("reset_hreadyout", 32'(HREADYOUT), 1);
    check("reset_hresp", 32'(HRESP), 0);
    cons_q.delete();
    @(negedge clk); #2;
    nReset = 1'b1;
    repeat (6) begin @(negedge clk); check("post_reset_request", 32'({wen, ren}), 0); end
    check("exp_q_empty", 32'(exp_q.size() + bus_q.size() + cons_q.size()), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
